// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use interlock, mult/div front-end hold, branch squash.
// Optional stall_cnt output enabled by defining PIPE_STALL_CNT_EN.
`timescale 1ns/1ps

module pipe_hazard_ctrl #(
    parameter int MD_MAX    = 32,
    parameter int FLUSH_CYC = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic [4:0] dec_opcode,
    input  logic [4:0] dec_aluop,
    input  logic [4:0] dec_rd,
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       ex_valid,
    input  logic       ex_lw,
    input  logic [4:0] ex_rd,
    input  logic       br_taken,
    input  logic       md_rdy,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_bubble,
    output logic       flush_ifid,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_err
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [7:0] MD_LIMIT = 8'(MD_MAX);
    localparam bit         FLUSH_2  = (FLUSH_CYC == 2);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [7:0] cnt;
    logic [7:0] cnt_d;
    logic       err_set;

    logic       rt_read;
    logic       rd_read;
    logic       src_hit;
    logic       lu;
    logic       mdi;

    // rs is always a source; rt only for R-type; rd doubles as a source for stores, compare-branches and jr.
    assign rt_read = (dec_opcode == OP_RTYPE);
    assign rd_read = (dec_opcode == OP_SW) || (dec_opcode == OP_BNE) ||
                     (dec_opcode == OP_BLT) || (dec_opcode == OP_JR);

    assign src_hit = (ex_rd == dec_rs) ||
                     (rt_read && (ex_rd == dec_rt)) ||
                     (rd_read && (ex_rd == dec_rd));

    assign lu  = dec_valid && ex_valid && ex_lw && (ex_rd != 5'd0) && src_hit;
    assign mdi = dec_valid && (dec_opcode == OP_RTYPE) &&
                 ((dec_aluop == ALU_MUL) || (dec_aluop == ALU_DIV));

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        err_set     = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_bubble = 1'b0;
        flush_ifid  = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        case (state)
            ST_RUN: begin
                if (br_taken) begin
                    flush_ifid  = 1'b1;
                    idex_bubble = 1'b1;
                    if (FLUSH_2) begin
                        state_d = ST_FLUSH;
                    end
                end else if (lu) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                end else if (mdi) begin
                    // The mult/div itself proceeds into ID/EX; only the front end freezes.
                    md_start = 1'b1;
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    state_d  = ST_MD_WAIT;
                    cnt_d    = 8'd1;
                end
            end
            ST_MD_WAIT: begin
                md_busy     = 1'b1;
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                cnt_d       = cnt + 8'd1;
                if (md_rdy) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else if (cnt == MD_LIMIT) begin
                    err_set = 1'b1;
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            end
            ST_FLUSH: begin
                flush_ifid  = 1'b1;
                idex_bubble = 1'b1;
                state_d     = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_RUN;
            cnt    <= 8'd0;
            md_err <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (err_set) begin
                md_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturating count of cycles where the PC is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 16'd0;
        end else if (!pc_en && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized run against a behavioural model.
// Two instances: default (MD_MAX=32, FLUSH_CYC=1) and short (MD_MAX=5, FLUSH_CYC=2).
`timescale 1ns/1ps

module tb_pipe_hazard_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       dec_valid, ex_valid, ex_lw, br_taken, md_rdy;
    logic [4:0] dec_opcode, dec_aluop, dec_rd, dec_rs, dec_rt, ex_rd;
    logic [1:0] pc_en_v, ifid_en_v, bub_v, flush_v, start_v, busy_v, err_v;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_v [2];
`endif

    int checks   = 0;
    int failures = 0;

    int md_max_m [2] = '{32, 5};
    int fcyc_m   [2] = '{1, 2};

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MD_MAX(32), .FLUSH_CYC(1)) u_dut0 (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_aluop(dec_aluop),
        .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .ex_valid(ex_valid), .ex_lw(ex_lw), .ex_rd(ex_rd),
        .br_taken(br_taken), .md_rdy(md_rdy),
        .pc_en(pc_en_v[0]), .ifid_en(ifid_en_v[0]), .idex_bubble(bub_v[0]),
        .flush_ifid(flush_v[0]), .md_start(start_v[0]), .md_busy(busy_v[0]),
        .md_err(err_v[0])
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_v[0])
`endif
    );

    pipe_hazard_ctrl #(.MD_MAX(5), .FLUSH_CYC(2)) u_dut1 (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode), .dec_aluop(dec_aluop),
        .dec_rd(dec_rd), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .ex_valid(ex_valid), .ex_lw(ex_lw), .ex_rd(ex_rd),
        .br_taken(br_taken), .md_rdy(md_rdy),
        .pc_en(pc_en_v[1]), .ifid_en(ifid_en_v[1]), .idex_bubble(bub_v[1]),
        .flush_ifid(flush_v[1]), .md_start(start_v[1]), .md_busy(busy_v[1]),
        .md_err(err_v[1])
`ifdef PIPE_STALL_CNT_EN
        , .stall_cnt(stall_v[1])
`endif
    );

    function automatic logic [6:0] outs(input int i);
        return {pc_en_v[i], ifid_en_v[i], bub_v[i], flush_v[i], start_v[i], busy_v[i], err_v[i]};
    endfunction

    task automatic idle();
        dec_valid = 0; dec_opcode = 0; dec_aluop = 0; dec_rd = 0; dec_rs = 0; dec_rt = 0;
        ex_valid = 0; ex_lw = 0; ex_rd = 0; br_taken = 0; md_rdy = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic set_dec(input logic [4:0] op, input logic [4:0] alu,
                           input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        dec_valid = 1; dec_opcode = op; dec_aluop = alu; dec_rd = rd; dec_rs = rs; dec_rt = rt;
    endtask

    task automatic set_ex_lw(input logic [4:0] rd);
        ex_valid = 1; ex_lw = 1; ex_rd = rd;
    endtask

    // Behavioural reference: which registers the decode instruction reads.
    function automatic bit model_reads(input logic [4:0] r);
        bit hit;
        hit = (r == dec_rs);
        if (dec_opcode == 5'd0 && r == dec_rt) hit = 1;
        if ((dec_opcode == 5'd7 || dec_opcode == 5'd2 || dec_opcode == 5'd6 || dec_opcode == 5'd4)
            && r == dec_rd) hit = 1;
        return hit;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outs(i) !== 7'b1100000) begin
                failures++;
                $display("FAIL reset_hold inst%0d got=%b exp=%b", i, outs(i), 7'b1100000);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outs(i) !== 7'b1100000) begin
                failures++;
                $display("FAIL reset_release inst%0d got=%b exp=%b", i, outs(i), 7'b1100000);
            end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        tick();
        set_ex_lw(5'd5);
        set_dec(5'd0, 5'd0, 5'd9, 5'd5, 5'd3);
        #1;
        checks++;
        if ({pc_en_v[0], ifid_en_v[0], bub_v[0]} !== 3'b001) begin
            failures++;
            $display("FAIL lu_rs_stall got=%b exp=001", {pc_en_v[0], ifid_en_v[0], bub_v[0]});
        end
        tick();
        ex_valid = 0; ex_lw = 0;
        #1;
        checks++;
        if ({pc_en_v[0], ifid_en_v[0], bub_v[0]} !== 3'b110) begin
            failures++;
            $display("FAIL lu_release got=%b exp=110", {pc_en_v[0], ifid_en_v[0], bub_v[0]});
        end
        tick();
        set_ex_lw(5'd3);
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b01) begin
            failures++;
            $display("FAIL lu_rt_stall got=%b exp=01", {pc_en_v[0], bub_v[0]});
        end
        dec_valid = 0;
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b10) begin
            failures++;
            $display("FAIL lu_dec_invalid got=%b exp=10", {pc_en_v[0], bub_v[0]});
        end
        tick();
        set_ex_lw(5'd0);
        set_dec(5'd0, 5'd0, 5'd1, 5'd0, 5'd0);
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b10) begin
            failures++;
            $display("FAIL lu_rd_zero got=%b exp=10", {pc_en_v[0], bub_v[0]});
        end
    endtask

    task automatic test_rd_source();
        tick();
        set_ex_lw(5'd7);
        set_dec(5'd7, 5'd0, 5'd7, 5'd1, 5'd2);
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b01) begin
            failures++;
            $display("FAIL sw_rd_stall got=%b exp=01", {pc_en_v[0], bub_v[0]});
        end
        tick();
        set_dec(5'd8, 5'd0, 5'd7, 5'd1, 5'd7);
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b10) begin
            failures++;
            $display("FAIL lw_no_rd_rt got=%b exp=10", {pc_en_v[0], bub_v[0]});
        end
        tick();
        set_dec(5'd4, 5'd0, 5'd7, 5'd1, 5'd2);
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0]} !== 2'b01) begin
            failures++;
            $display("FAIL jr_rd_stall got=%b exp=01", {pc_en_v[0], bub_v[0]});
        end
        tick();
        idle();
    endtask

    task automatic test_mul();
        int busy_n [2];
        int low_n, start_n, bub_n;
        do_reset();
        tick();
        set_dec(5'd0, 5'd6, 5'd3, 5'd1, 5'd2);
        #1;
        checks++;
        if ({start_v[0], pc_en_v[0], ifid_en_v[0], bub_v[0]} !== 4'b1000) begin
            failures++;
            $display("FAIL mul_issue got=%b exp=1000", {start_v[0], pc_en_v[0], ifid_en_v[0], bub_v[0]});
        end
        low_n = 1; start_n = 1; bub_n = 0; busy_n = '{0, 0};
        for (int c = 0; c < 6; c++) begin
            tick();
            dec_valid = 0;
            md_rdy = (c == 5);
            #1;
            for (int i = 0; i < 2; i++) if (busy_v[i]) busy_n[i]++;
            if (!pc_en_v[0]) low_n++;
            if (start_v[0]) start_n++;
            if (bub_v[0]) bub_n++;
        end
        tick();
        md_rdy = 0;
        #1;
        checks++;
        if (busy_n[0] != 6 || low_n != 7 || start_n != 1 || bub_n != 6) begin
            failures++;
            $display("FAIL mul_counts got busy=%0d low=%0d start=%0d bub=%0d exp 6 7 1 6",
                     busy_n[0], low_n, start_n, bub_n);
        end
        checks++;
        if ({pc_en_v[0], busy_v[0], err_v[0]} !== 3'b100) begin
            failures++;
            $display("FAIL mul_done got=%b exp=100", {pc_en_v[0], busy_v[0], err_v[0]});
        end
        checks++;
        if (busy_n[1] != 5 || err_v[1] !== 1'b1) begin
            failures++;
            $display("FAIL short_timeout got busy=%0d err=%b exp 5 1", busy_n[1], err_v[1]);
        end
        md_rdy = 1;
        tick();
        md_rdy = 0;
        #1;
        checks++;
        if ({pc_en_v[0], busy_v[0]} !== 2'b10) begin
            failures++;
            $display("FAIL rdy_in_run got=%b exp=10", {pc_en_v[0], busy_v[0]});
        end
    endtask

    task automatic test_div_timeout();
        int busy_n [2];
        bit early_err [2];
        do_reset();
        tick();
        set_dec(5'd0, 5'd7, 5'd3, 5'd1, 5'd2);
        busy_n = '{0, 0};
        early_err = '{0, 0};
        for (int c = 0; c < 40; c++) begin
            tick();
            dec_valid = 0;
            #1;
            for (int i = 0; i < 2; i++) begin
                if (busy_v[i]) begin
                    busy_n[i]++;
                    if (err_v[i]) early_err[i] = 1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy_n[i] != md_max_m[i] || early_err[i] || {err_v[i], pc_en_v[i], busy_v[i]} !== 3'b110) begin
                failures++;
                $display("FAIL div_timeout inst%0d got busy=%0d early=%0b st=%b exp busy=%0d early=0 st=110",
                         i, busy_n[i], early_err[i], {err_v[i], pc_en_v[i], busy_v[i]}, md_max_m[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        set_dec(5'd0, 5'd6, 5'd3, 5'd1, 5'd2);
        tick();
        dec_valid = 0;
        #1;
        checks++;
        if ({busy_v[0], pc_en_v[0], err_v[0]} !== 3'b101) begin
            failures++;
            $display("FAIL pre_reset_wait got=%b exp=101", {busy_v[0], pc_en_v[0], err_v[0]});
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (outs(i) !== 7'b1100000) begin
                failures++;
                $display("FAIL async_reset inst%0d got=%b exp=%b", i, outs(i), 7'b1100000);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_branch();
        do_reset();
        tick();
        set_ex_lw(5'd5);
        set_dec(5'd0, 5'd6, 5'd1, 5'd5, 5'd2);
        br_taken = 1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({pc_en_v[i], ifid_en_v[i], bub_v[i], flush_v[i], start_v[i]} !== 5'b11110) begin
                failures++;
                $display("FAIL br_priority inst%0d got=%b exp=11110", i,
                         {pc_en_v[i], ifid_en_v[i], bub_v[i], flush_v[i], start_v[i]});
            end
        end
        tick();
        br_taken = 0;
        md_rdy = 1;
        dec_aluop = 5'd0;
        #1;
        checks++;
        if ({pc_en_v[0], bub_v[0], flush_v[0], pc_en_v[1], bub_v[1], flush_v[1], busy_v[1]} !== 7'b0101110) begin
            failures++;
            $display("FAIL flush_second got=%b exp=0101110",
                     {pc_en_v[0], bub_v[0], flush_v[0], pc_en_v[1], bub_v[1], flush_v[1], busy_v[1]});
        end
        tick();
        md_rdy = 0;
        #1;
        checks++;
        if ({pc_en_v[1], bub_v[1], flush_v[1]} !== 3'b010) begin
            failures++;
            $display("FAIL flush_end got=%b exp=010", {pc_en_v[1], bub_v[1], flush_v[1]});
        end
        tick();
        idle();
    endtask

`ifdef PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        #1;
        checks++;
        if (stall_v[0] !== 16'd0) begin
            failures++;
            $display("FAIL stall_cnt_reset got=%0d exp=0", stall_v[0]);
        end
        tick();
        set_ex_lw(5'd5);
        set_dec(5'd0, 5'd0, 5'd1, 5'd5, 5'd2);
        tick();
        ex_valid = 0; ex_lw = 0;
        dec_aluop = 5'd6;
        for (int c = 0; c < 6; c++) begin
            tick();
            dec_valid = 0;
            md_rdy = (c == 5);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_v[0] !== 16'd8 || stall_v[1] !== 16'd7) begin
            failures++;
            $display("FAIL stall_cnt got=%0d/%0d exp=8/7", stall_v[0], stall_v[1]);
        end
    endtask
`endif

    task automatic test_random();
        int  m_wait  [2];
        bit  m_flush [2];
        bit  m_err   [2];
        int  m_stall [2];
        bit  lu_m, mdi_m;
        logic [5:0] ctl;
        logic [6:0] exp;
        logic [4:0] ops [8] = '{5'd0, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd1, 5'd3};
        logic [4:0] alus [4] = '{5'd6, 5'd7, 5'd0, 5'd1};
        int errs_before;
        do_reset();
        m_wait = '{0, 0}; m_flush = '{0, 0}; m_err = '{0, 0}; m_stall = '{0, 0};
        errs_before = failures;
        for (int c = 0; c < 400; c++) begin
            tick();
            dec_valid  = ($urandom_range(0, 9) < 8);
            dec_opcode = ops[$urandom_range(0, 7)];
            dec_aluop  = alus[$urandom_range(0, 3)];
            dec_rd     = 5'($urandom_range(0, 3));
            dec_rs     = 5'($urandom_range(0, 3));
            dec_rt     = 5'($urandom_range(0, 3));
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_lw      = $urandom_range(0, 1);
            ex_rd      = 5'($urandom_range(0, 3));
            br_taken   = ($urandom_range(0, 6) == 0);
            md_rdy     = ($urandom_range(0, 4) == 0);
            #1;
            lu_m  = dec_valid && ex_valid && ex_lw && ex_rd != 0 && model_reads(ex_rd);
            mdi_m = dec_valid && dec_opcode == 0 && (dec_aluop == 6 || dec_aluop == 7);
            for (int i = 0; i < 2; i++) begin
                if (m_wait[i] > 0)   ctl = 6'b001001;
                else if (m_flush[i]) ctl = 6'b111100;
                else if (br_taken)   ctl = 6'b111100;
                else if (lu_m)       ctl = 6'b001000;
                else if (mdi_m)      ctl = 6'b000010;
                else                 ctl = 6'b110000;
                exp = {ctl, m_err[i]};
                checks++;
                if (outs(i) !== exp) begin
                    failures++;
                    if (failures - errs_before <= 10)
                        $display("FAIL random cyc%0d inst%0d got=%b exp=%b", c, i, outs(i), exp);
                end
`ifdef PIPE_STALL_CNT_EN
                checks++;
                if (stall_v[i] !== 16'(m_stall[i])) begin
                    failures++;
                    if (failures - errs_before <= 10)
                        $display("FAIL random_stall cyc%0d inst%0d got=%0d exp=%0d", c, i, stall_v[i], m_stall[i]);
                end
`endif
                if (!ctl[5] && m_stall[i] < 65535) m_stall[i]++;
                if (m_wait[i] > 0) begin
                    if (md_rdy) m_wait[i] = 0;
                    else if (m_wait[i] == md_max_m[i]) begin
                        m_wait[i] = 0;
                        m_err[i] = 1;
                    end else m_wait[i]++;
                end else if (m_flush[i]) m_flush[i] = 0;
                else if (br_taken) m_flush[i] = (fcyc_m[i] == 2);
                else if (!lu_m && mdi_m) m_wait[i] = 1;
            end
        end
        tick();
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_rd_source();
        test_mul();
        test_div_timeout();
        test_async_reset();
        test_branch();
`ifdef PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
